// File: rtl/order_book_pkg.sv
// Shared types and constants for the limit order book matcher.
// Side encoding, FSM states and empty-book sentinel fill bits.
package order_book_pkg;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MATCH,
    INSERT
  } state_e;

  // Replicated to PRICE_W: empty bid book reads 0, empty ask reads all-ones
  localparam logic BID_EMPTY_BIT = 1'b0;
  localparam logic ASK_EMPTY_BIT = 1'b1;

endpackage

// File: rtl/ob_book_side.sv
// One side of the book: compacted arrival-ordered storage,
// best-entry scan, append and decrement/remove-with-shift.
module ob_book_side
  import order_book_pkg::*;
#(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH+1),
  parameter bit IS_BID  = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               app_i,
  input  logic [PRICE_W-1:0] app_price_i,
  input  logic [QTY_W-1:0]   app_qty_i,
  input  logic               dec_i,
  input  logic [QTY_W-1:0]   dec_qty_i,
  output logic [PRICE_W-1:0] best_price_o,
  output logic [QTY_W-1:0]   best_qty_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic EMPTY_BIT = IS_BID ? BID_EMPTY_BIT : ASK_EMPTY_BIT;

  logic [PRICE_W-1:0] price_q [DEPTH];
  logic [PRICE_W-1:0] price_d [DEPTH];
  logic [QTY_W-1:0]   qty_q   [DEPTH];
  logic [QTY_W-1:0]   qty_d   [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   best_idx;
  logic [PRICE_W-1:0] best_p;

  // Best-price scan; strict compare keeps the oldest entry on ties
  always_comb begin
    best_idx = '0;
    best_p   = price_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        if (IS_BID ? (price_q[i] > best_p) : (price_q[i] < best_p)) begin
          best_idx = IDX_W'(i);
          best_p   = price_q[i];
        end
      end
    end
  end

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign count_o      = count_q;
  assign best_price_o = empty_o ? {PRICE_W{EMPTY_BIT}} : best_p;
  assign best_qty_o   = qty_q[best_idx];

  // Next book contents: fill against best entry, or append at the tail
  always_comb begin
    price_d = price_q;
    qty_d   = qty_q;
    count_d = count_q;
    if (dec_i && !empty_o) begin
      if (dec_qty_i >= qty_q[best_idx]) begin
        for (int i = 0; i < DEPTH-1; i++) begin
          if (IDX_W'(i) >= best_idx) begin
            price_d[i] = price_q[i+1];
            qty_d[i]   = qty_q[i+1];
          end
        end
        count_d = count_q - CNT_W'(1);
      end else begin
        qty_d[best_idx] = qty_q[best_idx] - dec_qty_i;
      end
    end
    if (app_i && !full_o) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == count_q) begin
          price_d[i] = app_price_i;
          qty_d[i]   = app_qty_i;
        end
      end
      count_d = count_q + CNT_W'(1);
    end
  end

  // Book storage registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        price_q[i] <= '0;
        qty_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      price_q <= price_d;
      qty_q   <= qty_d;
    end
  end

endmodule

// File: rtl/order_book_matcher.sv
// Price-time priority limit order book matcher, one fill per cycle.
// ORDER_BOOK_MIDPOINT_EN: trade at floor of aggressor/resting midpoint.
module order_book_matcher
  import order_book_pkg::*;
#(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_side,
  input  logic [PRICE_W-1:0] in_price,
  input  logic [QTY_W-1:0]   in_qty,
  output logic               trade_valid,
  output logic [PRICE_W-1:0] trade_price,
  output logic [QTY_W-1:0]   trade_qty,
  output logic               trade_side,
  output logic               reject,
  output logic [PRICE_W-1:0] best_bid,
  output logic [PRICE_W-1:0] best_ask,
  output logic [CNT_W-1:0]   bid_count,
  output logic [CNT_W-1:0]   ask_count
);

  state_e             state_q, state_d;
  logic               agg_side_q, agg_side_d;
  logic [PRICE_W-1:0] agg_price_q, agg_price_d;
  logic [QTY_W-1:0]   agg_qty_q, agg_qty_d;
  logic               tv_q, tv_d, ts_q, ts_d, rej_q, rej_d;
  logic [PRICE_W-1:0] tp_q, tp_d, exec_price;
  logic [QTY_W-1:0]   tq_q, tq_d, fill;

  logic               bid_app, ask_app, bid_dec, ask_dec;
  logic [QTY_W-1:0]   bid_bq, ask_bq, opp_qty;
  logic               bid_empty, ask_empty, bid_full, ask_full;
  logic [PRICE_W-1:0] opp_price;
  logic               opp_empty, own_full, is_buy, crosses;

  ob_book_side #(
    .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH),
    .CNT_W(CNT_W), .IS_BID(1'b1)
  ) u_bid (
    .clk_i(clk), .reset_i(reset),
    .app_i(bid_app), .app_price_i(agg_price_q), .app_qty_i(agg_qty_q),
    .dec_i(bid_dec), .dec_qty_i(fill),
    .best_price_o(best_bid), .best_qty_o(bid_bq), .count_o(bid_count),
    .empty_o(bid_empty), .full_o(bid_full)
  );

  ob_book_side #(
    .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH),
    .CNT_W(CNT_W), .IS_BID(1'b0)
  ) u_ask (
    .clk_i(clk), .reset_i(reset),
    .app_i(ask_app), .app_price_i(agg_price_q), .app_qty_i(agg_qty_q),
    .dec_i(ask_dec), .dec_qty_i(fill),
    .best_price_o(best_ask), .best_qty_o(ask_bq), .count_o(ask_count),
    .empty_o(ask_empty), .full_o(ask_full)
  );

  assign is_buy    = (agg_side_q == SIDE_BUY);
  assign opp_price = is_buy ? best_ask : best_bid;
  assign opp_qty   = is_buy ? ask_bq : bid_bq;
  assign opp_empty = is_buy ? ask_empty : bid_empty;
  assign own_full  = is_buy ? bid_full : ask_full;
  assign crosses   = !opp_empty && (agg_qty_q != '0) &&
                     (is_buy ? (agg_price_q >= opp_price)
                             : (agg_price_q <= opp_price));
  assign fill      = (agg_qty_q < opp_qty) ? agg_qty_q : opp_qty;

`ifdef ORDER_BOOK_MIDPOINT_EN
  logic [PRICE_W:0] px_sum;
  assign px_sum     = {1'b0, agg_price_q} + {1'b0, opp_price};
  assign exec_price = px_sum[PRICE_W:1];
`else
  assign exec_price = opp_price;
`endif

  assign in_ready    = (state_q == IDLE);
  assign trade_valid = tv_q;
  assign trade_price = tp_q;
  assign trade_qty   = tq_q;
  assign trade_side  = ts_q;
  assign reject      = rej_q;

  // FSM next state, book commands and trade/reject outputs
  always_comb begin
    state_d     = state_q;
    agg_side_d  = agg_side_q;
    agg_price_d = agg_price_q;
    agg_qty_d   = agg_qty_q;
    tv_d        = 1'b0;
    tp_d        = tp_q;
    tq_d        = tq_q;
    ts_d        = ts_q;
    rej_d       = 1'b0;
    bid_app     = 1'b0;
    ask_app     = 1'b0;
    bid_dec     = 1'b0;
    ask_dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          agg_side_d  = in_side;
          agg_price_d = in_price;
          agg_qty_d   = in_qty;
          state_d     = (in_qty == '0) ? INSERT : MATCH;
        end
      end
      MATCH: begin
        if (crosses) begin
          tv_d      = 1'b1;
          tp_d      = exec_price;
          tq_d      = fill;
          ts_d      = agg_side_q;
          agg_qty_d = agg_qty_q - fill;
          ask_dec   = is_buy;
          bid_dec   = !is_buy;
        end else begin
          state_d = (agg_qty_q != '0) ? INSERT : IDLE;
        end
      end
      INSERT: begin
        if ((agg_qty_q == '0) || own_full) begin
          rej_d = 1'b1;
        end else begin
          bid_app = is_buy;
          ask_app = !is_buy;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, aggressor and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      agg_side_q  <= SIDE_BUY;
      agg_price_q <= '0;
      agg_qty_q   <= '0;
      tv_q        <= 1'b0;
      tp_q        <= '0;
      tq_q        <= '0;
      ts_q        <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      agg_side_q  <= agg_side_d;
      agg_price_q <= agg_price_d;
      agg_qty_q   <= agg_qty_d;
      tv_q        <= tv_d;
      tp_q        <= tp_d;
      tq_q        <= tq_d;
      ts_q        <= ts_d;
      rej_q       <= rej_d;
    end
  end

endmodule
